// File: rtl/conv_pkg.sv
// Shared constants, enums and puncturing tables for the K=7 802.11a/g convolutional encoder.
package conv_pkg;

    localparam int K = 7;
    // Tap vector layout is {b, s1, s2, s3, s4, s5, s6}, MSB first.
    localparam logic [K-1:0] G0 = 7'o133;
    localparam logic [K-1:0] G1 = 7'o171;

    typedef enum logic [1:0] {
        R12 = 2'd0,
        R23 = 2'd1,
        R34 = 2'd2
    } rate_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TAIL  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef logic [1:0] phase_t;
    typedef logic [1:0] punct_t;    // {emit A, emit B}

    function automatic rate_e decode_rate(input logic [1:0] r);
        case (r)
            2'b01:   return R23;
            2'b10:   return R34;
            default: return R12;
        endcase
    endfunction

    function automatic phase_t phase_mod(input rate_e r);
        case (r)
            R23:     return 2'd2;
            R34:     return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    function automatic punct_t punct_mask(input rate_e r, input phase_t p);
        punct_t m;
        m = 2'b11;
        if (p == 2'd1 && r != R12) begin
            m = 2'b10;
        end else if (p == 2'd2 && r == R34) begin
            m = 2'b01;
        end
        return m;
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Six-stage shift register and the two generator parity trees; A/B reflect the current input bit.
module conv_enc_core
    import conv_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enc_bit,
    input  logic enable,
    input  logic clear,
    output logic a,
    output logic b
);

    logic [K-2:0] sr_reg;   // sr_reg[0] = s1 (newest) ... sr_reg[K-2] = s6
    logic [K-1:0] taps;

    assign taps[K-1] = enc_bit;

    genvar gi;
    generate
        for (gi = 1; gi < K; gi++) begin : g_taps
            assign taps[K-1-gi] = sr_reg[gi-1];
        end
    endgenerate

    assign a = ^(taps & G0);
    assign b = ^(taps & G1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_reg <= '0;
        end else if (clear) begin
            sr_reg <= '0;
        end else if (enable) begin
            sr_reg <= {sr_reg[K-3:0], enc_bit};
        end
    end

endmodule

// File: rtl/conv_encoder.sv
// Framed K=7 convolutional encoder with puncturing, zero-tail insertion and a
// two-entry output hold register behind a valid/ready handshake.
module conv_encoder
    import conv_pkg::*;
#(
    parameter int TAIL_BITS = 6
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] rate,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_last,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);

    localparam int TW = (TAIL_BITS > 1) ? $clog2(TAIL_BITS) : 1;
    localparam logic [TW-1:0] TAIL_LAST = TW'((TAIL_BITS > 0) ? TAIL_BITS - 1 : 0);

    state_e          state_reg, state_next;
    rate_e           rate_reg;
    rate_e           cur_rate;
    phase_t          phase_reg;
    phase_t          phase_next;
    punct_t          mask;
    logic [TW-1:0]   tail_cnt_reg;

    // Head of the hold register is the presented output; the second slot holds B.
    logic            out_valid_reg, out_bit_reg, out_last_reg;
    logic            second_valid_reg, second_bit_reg, second_last_reg;

    logic            load, take, tail_go, tail_done, drain_done;
    logic            enc_en, enc_bit, frame_last;
    logic            enc_a, enc_b;

    assign load       = !second_valid_reg && (!out_valid_reg || out_ready);
    assign in_ready   = (state_reg == IDLE || state_reg == DATA) && load;
    assign take       = in_valid && in_ready;
    assign tail_go    = (state_reg == TAIL) && load;
    assign tail_done  = tail_go && (tail_cnt_reg == TAIL_LAST);
    assign drain_done = (state_reg == DRAIN) && !out_valid_reg && !second_valid_reg;
    assign enc_en     = take || tail_go;
    assign enc_bit    = (state_reg == TAIL) ? 1'b0 : in_bit;
    assign frame_last = (state_reg == TAIL) ? tail_done
                                            : (take && in_last && (TAIL_BITS == 0));

    // The first bit of a frame is encoded with the rate presented alongside it.
    assign cur_rate   = (state_reg == IDLE) ? decode_rate(rate) : rate_reg;
    assign mask       = punct_mask(cur_rate, phase_reg);
    assign phase_next = (phase_reg == phase_mod(cur_rate) - 2'd1) ? 2'd0 : phase_reg + 2'd1;

    assign busy       = (state_reg != IDLE);
    assign out_bit    = out_bit_reg;
    assign out_valid  = out_valid_reg;
    assign out_last   = out_last_reg;

    conv_enc_core u_core (
        .clk     (clk),
        .reset   (reset),
        .enc_bit (enc_bit),
        .enable  (enc_en),
        .clear   (drain_done),
        .a       (enc_a),
        .b       (enc_b)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DATA: begin
                if (take) begin
                    if (in_last) begin
                        state_next = (TAIL_BITS > 0) ? TAIL : DRAIN;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            TAIL: begin
                if (tail_done) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            rate_reg     <= R12;
            phase_reg    <= '0;
            tail_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (take && state_reg == IDLE) begin
                rate_reg <= decode_rate(rate);
            end
            if (drain_done) begin
                phase_reg <= '0;
            end else if (enc_en) begin
                phase_reg <= phase_next;
            end
            if (tail_done || drain_done) begin
                tail_cnt_reg <= '0;
            end else if (tail_go) begin
                tail_cnt_reg <= tail_cnt_reg + 1'b1;
            end
        end
    end

    // A new encoded bit only loads when the head is free or leaving this cycle,
    // so it may overwrite the head but never a queued B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg    <= 1'b0;
            out_bit_reg      <= 1'b0;
            out_last_reg     <= 1'b0;
            second_valid_reg <= 1'b0;
            second_bit_reg   <= 1'b0;
            second_last_reg  <= 1'b0;
        end else if (enc_en) begin
            out_valid_reg <= 1'b1;
            case (mask)
                2'b10: begin
                    out_bit_reg      <= enc_a;
                    out_last_reg     <= frame_last;
                    second_valid_reg <= 1'b0;
                end
                2'b01: begin
                    out_bit_reg      <= enc_b;
                    out_last_reg     <= frame_last;
                    second_valid_reg <= 1'b0;
                end
                default: begin
                    out_bit_reg      <= enc_a;
                    out_last_reg     <= 1'b0;
                    second_valid_reg <= 1'b1;
                    second_bit_reg   <= enc_b;
                    second_last_reg  <= frame_last;
                end
            endcase
        end else if (out_valid_reg && out_ready) begin
            if (second_valid_reg) begin
                out_bit_reg      <= second_bit_reg;
                out_last_reg     <= second_last_reg;
                second_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= 1'b0;
                out_bit_reg   <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Transmit-side K=7 convolutional encoder for the 802.11a/g OFDM PHY, the counterpart of the receive-side Viterbi decoder. It accepts a serial data bitstream with a valid/ready handshake and encodes it with generators g0=133₈ (A) and g1=171₈ (B). It punctures the coded stream to rate 1/2, 2/3 or 3/4, optionally appends zero tail bits, and emits one coded bit per cycle toward the interleaver.

## Interface
Parameters:
- TAIL_BITS, 6: zero bits injected after `in_last`; 0 disables tail insertion.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rate  in  2  00=1/2, 01=2/3, 10=3/4, 11 is treated as 1/2; sampled on the first accepted bit of a frame.
- in_bit  in  1  data bit.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  encoder accepts in_bit this cycle.
- in_last  in  1  marks the final data bit of the frame; qualified by in_valid & in_ready.
- out_bit  out  1  coded bit.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  downstream accepts out_bit.
- out_last  out  1  marks the final coded bit of the frame.
- busy  out  1  high in every state except IDLE.

## Operation
- Shift register s[1:6] holds the previous 6 input bits, with s1 the newest. It is zero at reset and at the start of every frame.
- A = b^s2^s3^s5^s6.
- B = b^s1^s2^s3^s6.
- Phase counter p: modulo 1 at rate 1/2, modulo 2 at rate 2/3, modulo 3 at rate 3/4. It advances on every encoded bit, data or tail, and resets to 0 at frame start.
- Puncture masks, with emission order always A then B:
  - rate 1/2: p0 emits AB.
  - rate 2/3: p0 emits AB, p1 emits A.
  - rate 3/4: p0 emits AB, p1 emits A, p2 emits B.
- Each encoded bit loads a 2-entry hold register {A,B}, a pending mask and a last flag. Every phase emits at least one bit.
- FSM:
  - IDLE: in_ready=1. An accepted bit latches `rate`, encodes, and moves to DATA. If the bit carries in_last, go to TAIL (TAIL_BITS>0) or DRAIN.
  - DATA: accepts bits per the in_ready rule. An accepted in_last goes to TAIL (TAIL_BITS>0) or DRAIN.
  - TAIL: in_ready=0. A tail counter injects TAIL_BITS zero bits, each under the same load rule as data. After the final tail bit is loaded, go to DRAIN.
  - DRAIN: in_ready=0. When the hold register empties, clear the shift register and p, then go to IDLE.
- Load rule: a new bit loads when pending=0, or when pending=1 and out_ready=1 (the single pending bit transfers this cycle).
  - In IDLE/DATA, in_ready equals the load rule. This is a combinational path from out_ready to in_ready.
- out_last is high on the final emitted bit of the frame. That bit is the last tail bit's final coded bit, or the last data bit's final coded bit when TAIL_BITS=0.
- `rate` changes mid-frame are ignored.

## Timing
- Reset values:
  - State IDLE; out_valid=0, out_bit=0, out_last=0, busy=0.
  - in_ready=1 once reset deasserts; shift register, p and tail counter are 0.
- Latency: a bit accepted at edge N produces out_valid with its first coded bit in the cycle after edge N.
- out_bit, out_valid and out_last are registered.
- Output handshake: out_bit and out_last stay stable while out_valid=1 and out_ready=0.
- Throughput with out_ready held high:
  - 1 coded bit per cycle.
  - rate 1/2: 1 input per 2 cycles.
  - rate 2/3: 2 inputs per 3 cycles.
  - rate 3/4: 3 inputs per 4 cycles.
- Between frames: DRAIN→IDLE costs one cycle after the last coded bit transfers. The next frame's first bit is accepted no earlier than that.
- Reset mid-frame: outputs drop in the same cycle (asynchronous). The frame is abandoned and the next frame starts from a zero register.
- A held-off output (out_ready=0 indefinitely) never drops or duplicates bits. in_ready stays 0 while pending≥1 and out_ready=0.

## Structure
- Package conv_pkg:
  - G0=7'o133 and G1=7'o171.
  - K=7.
  - Rate enum {R12, R23, R34}.
  - Per-rate phase modulus and puncture masks.
  - FSM state enum {IDLE, DATA, TAIL, DRAIN}.
- Sub-module conv_enc_core: shift register plus generator XORs. Inputs are bit, enable and clear; outputs are A and B.
- The top level holds the FSM, phase/tail counters, hold register and handshakes.

## Test plan
- Impulse, rate 1/2, TAIL_BITS=6: one bit 1 with in_last, out_ready=1.
  - Expect 14 bits 1,1,0,1,1,1,1,1,0,0,1,0,1,1, with out_last on bit 14.
- Same impulse at rate 2/3.
  - Expect 11 bits 1,1,0,1,1,1,0,0,1,1,1, with out_last on bit 11.
- Rate 3/4, 3 zero data bits plus tail.
  - Expect 12 zero bits, out_last on bit 12, and in_ready=0 during TAIL/DRAIN.
- Back-pressure: impulse at rate 1/2 with out_ready toggling at random.
  - Expect the output sequence identical to the first test, out_bit stable while stalled, and no in_ready while pending and stalled.
- Back-to-back frames: impulse then impulse, rate 1/2.
  - Expect two identical 14-bit sequences; the second is unaffected by the first.
  - The second frame's first accept is ≥1 cycle after the first frame's out_last transfer.
- Reset asserted mid-TAIL.
  - Expect out_valid=0 and busy=0 immediately.
  - A new rate 1/2 impulse frame then yields the first test's sequence.
